// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button-release detection, centisecond prescaler and counter/display sequencing.
// Optional lap mode is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int TICK_W   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       cnt_inc,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_e;

  localparam logic [TICK_W-1:0] PRESC_TOP = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] PRESC_ONE = TICK_W'(1);

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              ss_q, ss_qq, lr_q, lr_qq;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              inc_q, inc_d;
  logic              clr_q, clr_d;
  logic              hold_q, hold_d;

  logic ss_ev, lr_ev;
  logic run_now, run_next, presc_top;

  // A release is the history pair seeing high-then-low; presses alone never fire.
  assign ss_ev     = ss_qq & ~ss_q;
  assign lr_ev     = lr_qq & ~lr_q;
  assign presc_top = (presc_q == PRESC_TOP);

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_ev) begin
          state_d = S_RUN;
        end else if (lr_ev) begin
          clr_d = 1'b1;
        end
      end
      S_RUN: begin
        if (ss_ev) begin
          state_d = S_PAUSE;
        end else if (lr_ev && LAP_EN) begin
          state_d = S_LAP;
        end
      end
      S_PAUSE: begin
        if (ss_ev) begin
          state_d = S_RUN;
        end else if (lr_ev) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      S_LAP: begin
        // Without lap support this encoding is illegal and falls back to IDLE.
        if (!LAP_EN) begin
          state_d = S_IDLE;
        end else if (ss_ev) begin
          state_d = S_PAUSE;
        end else if (lr_ev) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign run_now  = (state_q == S_RUN) || (LAP_EN && (state_q == S_LAP));
  assign run_next = (state_d == S_RUN) || (LAP_EN && (state_d == S_LAP));

  // The prescaler only advances on edges that stay in a counting state, so a
  // pause freezes its phase and the edge into PAUSE never emits an increment.
  always_comb begin
    presc_d = presc_q;
    inc_d   = 1'b0;
    if (clr_d || (state_d == S_IDLE)) begin
      presc_d = '0;
    end else if (run_now && run_next) begin
      inc_d   = presc_top;
      presc_d = presc_top ? '0 : (presc_q + PRESC_ONE);
    end
  end

  assign hold_d = LAP_EN && (state_d == S_LAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ss_q    <= 1'b0;
      ss_qq   <= 1'b0;
      lr_q    <= 1'b0;
      lr_qq   <= 1'b0;
      presc_q <= '0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= btn_ss;
      ss_qq   <= ss_q;
      lr_q    <= btn_lr;
      lr_qq   <= lr_q;
      presc_q <= presc_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
    end
  end

  assign cnt_inc   = inc_q;
  assign cnt_clr   = clr_q;
  assign disp_hold = hold_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=4) against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, btn_ss, btn_lr;
  logic       cnt_inc, cnt_clr, disp_hold;
  logic [1:0] state;

  int nvec = 0;
  int nerr = 0;

  // Model: mode, counted edges since last clear, expected registered outputs,
  // and the last two sampled levels of each button ([0] newest).
  int m_mode, m_elapsed;
  bit m_inc, m_clr, m_hold;
  bit ss_h[2], lr_h[2];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .TICK_W(20)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_ss   (btn_ss),
    .btn_lr   (btn_lr),
    .cnt_inc  (cnt_inc),
    .cnt_clr  (cnt_clr),
    .disp_hold(disp_hold),
    .state    (state)
  );

  function automatic logic [4:0] m_vec();
    return {2'(m_mode), m_inc, m_clr, m_hold};
  endfunction

  task automatic step();
    bit ss_ev, lr_ev, clr;
    int nxt;
    @(posedge clk);
    if (!rst_n) begin
      m_mode = IDLE; m_elapsed = 0; m_inc = 0; m_clr = 0; m_hold = 0;
      ss_h[0] = 0; ss_h[1] = 0; lr_h[0] = 0; lr_h[1] = 0;
    end else begin
      ss_ev = ss_h[1] && !ss_h[0];
      lr_ev = lr_h[1] && !lr_h[0];
      ss_h[1] = ss_h[0]; ss_h[0] = btn_ss;
      lr_h[1] = lr_h[0]; lr_h[0] = btn_lr;
      nxt = m_mode;
      clr = 0;
      if (ss_ev) begin
        nxt = (m_mode == IDLE || m_mode == PAUSE) ? RUN : PAUSE;
      end else if (lr_ev) begin
        if (m_mode == IDLE) clr = 1;
        else if (m_mode == RUN && LAP_EN) nxt = LAP;
        else if (m_mode == PAUSE) begin nxt = IDLE; clr = 1; end
        else if (m_mode == LAP) nxt = RUN;
      end
      m_inc = 0;
      if ((m_mode == RUN || m_mode == LAP) && (nxt == RUN || nxt == LAP)) begin
        m_elapsed++;
        m_inc = (m_elapsed % TD) == 0;
      end
      if (nxt == IDLE) m_elapsed = 0;
      m_mode = nxt;
      m_clr  = clr;
      m_hold = (nxt == LAP);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
    step(); step();
    nvec++;
    if ({state, cnt_inc, cnt_clr, disp_hold} !== 5'b0) begin
      nerr++; $display("FAIL reset_state: got %b expected %b", {state, cnt_inc, cnt_clr, disp_hold}, 5'b0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      nvec++;
      if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
        nerr++; $display("FAIL reset_idle: got %b expected %b", {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
      end
    end
  endtask

  task automatic test_start_tick();
    int pulses, first;
    btn_ss = 1'b1;
    repeat (3) step();
    btn_ss = 1'b0;
    step();
    nvec++;
    if (state !== 2'b00) begin
      nerr++; $display("FAIL start_early: got %b expected 00", state);
    end
    step();
    nvec++;
    if (state !== 2'b01) begin
      nerr++; $display("FAIL start_edge2: got %b expected 01", state);
    end
    pulses = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      nvec++;
      if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
        nerr++; $display("FAIL tick_seq: cycle %0d got %b expected %b", i, {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
      end
      if (cnt_inc === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    nvec++;
    if (pulses != 5 || first != TD) begin
      nerr++; $display("FAIL tick_count: got %0d pulses first at %0d, expected 5 first at %0d", pulses, first, TD);
    end
  endtask

  task automatic test_pause();
    int incs;
    btn_ss = 1'b1;
    for (int i = 0; i < 3 * TD && (m_elapsed % TD) != 1; i++) step();
    btn_ss = 1'b0;
    step(); step();
    nvec++;
    if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec() || state !== 2'b10 || (m_elapsed % TD) != 2) begin
      nerr++; $display("FAIL pause_enter: got %b expected %b", {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
    end
    incs = 0;
    repeat (10) begin
      step();
      if (cnt_inc !== 1'b0 || state !== 2'b10) incs++;
    end
    nvec++;
    if (incs != 0) begin
      nerr++; $display("FAIL pause_hold: got %0d bad cycles expected 0", incs);
    end
    btn_ss = 1'b1; step();
    btn_ss = 1'b0; step(); step();
    nvec++;
    if (state !== 2'b01) begin
      nerr++; $display("FAIL resume_state: got %b expected 01", state);
    end
    step();
    nvec++;
    if (cnt_inc !== 1'b0) begin
      nerr++; $display("FAIL resume_phase3: got %b expected 0", cnt_inc);
    end
    step();
    nvec++;
    if (cnt_inc !== 1'b1 || {state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
      nerr++; $display("FAIL resume_inc: got %b expected %b", {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
    end
  endtask

  task automatic test_clear();
    int clrs;
    btn_ss = 1'b1; step();
    btn_ss = 1'b0; step(); step();
    for (int pass = 0; pass < 2; pass++) begin
      btn_lr = 1'b1;
      repeat ($urandom_range(1, 4)) step();
      btn_lr = 1'b0;
      clrs = 0;
      repeat (5) begin
        step();
        nvec++;
        if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
          nerr++; $display("FAIL clear_seq: pass %0d got %b expected %b", pass, {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
        end
        if (cnt_clr === 1'b1) clrs++;
      end
      nvec++;
      if (clrs != 1 || state !== 2'b00) begin
        nerr++; $display("FAIL clear_once: pass %0d got %0d pulses state %b expected 1 pulses state 00", pass, clrs, state);
      end
    end
  endtask

  task automatic test_lap();
    int pulses, first;
    btn_ss = 1'b1; step();
    btn_ss = 1'b0; step(); step();
    first = -1;
    for (int i = 1; i <= TD; i++) begin
      step();
      if (cnt_inc === 1'b1 && first < 0) first = i;
    end
    nvec++;
    if (first != TD) begin
      nerr++; $display("FAIL restart_phase: got first inc at %0d expected %0d", first, TD);
    end
    btn_lr = 1'b1; step();
    btn_lr = 1'b0; step(); step();
    pulses = 0;
    repeat (12) begin
      step();
      nvec++;
      if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
        nerr++; $display("FAIL lap_seq: got %b expected %b", {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
      end
      if (cnt_inc === 1'b1) pulses++;
    end
    nvec++;
    if (state !== (LAP_EN ? 2'b11 : 2'b01) || disp_hold !== LAP_EN || pulses != 3) begin
      nerr++; $display("FAIL lap_enter: got state %b hold %b pulses %0d expected state %b hold %b pulses 3",
                       state, disp_hold, pulses, LAP_EN ? 2'b11 : 2'b01, LAP_EN);
    end
    btn_lr = 1'b1; step();
    btn_lr = 1'b0; step(); step();
    nvec++;
    if (state !== 2'b01 || disp_hold !== 1'b0) begin
      nerr++; $display("FAIL lap_exit: got state %b hold %b expected 01 0", state, disp_hold);
    end
  endtask

  task automatic test_simultaneous();
    int bad;
    btn_ss = 1'b1; btn_lr = 1'b1;
    repeat (2) step();
    btn_ss = 1'b0; btn_lr = 1'b0;
    bad = 0;
    repeat (4) begin
      step();
      nvec++;
      if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
        nerr++; $display("FAIL simul_seq: got %b expected %b", {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
      end
      if (cnt_clr !== 1'b0 || disp_hold !== 1'b0) bad++;
    end
    nvec++;
    if (state !== 2'b10 || bad != 0) begin
      nerr++; $display("FAIL simul_result: got state %b bad %0d expected 10 0", state, bad);
    end
  endtask

  task automatic test_reset_held();
    int changes;
    logic [1:0] prev;
    rst_n = 1'b0; btn_ss = 1'b1; btn_lr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    btn_ss = 1'b0;
    changes = 0; prev = state;
    repeat (6) begin
      step();
      if (state !== prev) changes++;
      prev = state;
    end
    nvec++;
    if (changes != 1 || state !== 2'b01) begin
      nerr++; $display("FAIL held_release: got %0d transitions state %b expected 1 state 01", changes, state);
    end
    repeat ($urandom_range(1, 7)) step();
    rst_n = 1'b0;
    step();
    nvec++;
    if ({state, cnt_inc, cnt_clr, disp_hold} !== 5'b0) begin
      nerr++; $display("FAIL mid_reset: got %b expected 00000", {state, cnt_inc, cnt_clr, disp_hold});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 200; seg++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      btn_ss = 1'($urandom_range(0, 1));
      btn_lr = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5)) begin
        step();
        nvec++;
        if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
          nerr++; $display("FAIL random_seq: seg %0d got %b expected %b", seg, {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
        end
      end
      rst_n = 1'b1;
      btn_ss = 1'b0; btn_lr = 1'b0;
      repeat ($urandom_range(1, 9)) begin
        step();
        nvec++;
        if ({state, cnt_inc, cnt_clr, disp_hold} !== m_vec()) begin
          nerr++; $display("FAIL random_seq: seg %0d got %b expected %b", seg, {state, cnt_inc, cnt_clr, disp_hold}, m_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_pause();
    test_clear();
    test_lap();
    test_simultaneous();
    test_reset_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
